// File: rtl/ula_pkg.sv
// ula_pkg: shared definitions for the stack-datapath ALU.
//   OPCODE_W : width of the opcode field.
//   opcode_e : operation encodings. Values 10..15 are reserved and give 0.
package ula_pkg;

    localparam int OPCODE_W = 4;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_DIV  = 4'd3,
        OP_AND  = 4'd4,
        OP_NAND = 4'd5,
        OP_OR   = 4'd6,
        OP_XOR  = 4'd7,
        OP_CMP  = 4'd8,
        OP_NOT  = 4'd9
    } opcode_e;

endpackage

// File: rtl/ula_if.sv
// ula_if: operand/opcode/result bundle between the stack control logic and the ALU.
//   operand_a, operand_b : unsigned top-of-stack operands
//   opcode               : operation select
//   out                  : registered result
// Modports: master = control side (drives operands), slave = ALU side.
interface ula_if
    import ula_pkg::*;
#(
    parameter int DATA_SIZE = 11
);
    logic [DATA_SIZE-1:0] operand_a;
    logic [DATA_SIZE-1:0] operand_b;
    logic [OPCODE_W-1:0]  opcode;
    logic [DATA_SIZE-1:0] out;

    modport master (output operand_a, output operand_b, output opcode, input out);
    modport slave  (input operand_a, input operand_b, input opcode, output out);
endinterface

// File: rtl/ula.sv
// ula: arithmetic/logic unit of the stack datapath.
// Computes f(opcode, A, B) combinationally and registers it: one cycle latency,
// one operation accepted every cycle, no handshake.
//   clk   : system clock, rising edge
//   reset : synchronous active-high, clears the result register
//   bus   : ula_if.slave (operand_a, operand_b, opcode in; out registered result)
module ula
    import ula_pkg::*;
#(
    parameter int DATA_SIZE = 11
) (
    input  logic clk,
    input  logic reset,
    ula_if.slave bus
);

    logic [DATA_SIZE-1:0] next_result;
    logic                 a_true;
    logic                 b_true;

    // Logical opcodes treat any nonzero operand as true.
    assign a_true = (bus.operand_a != '0);
    assign b_true = (bus.operand_b != '0);

    always_comb begin
        next_result = '0;
        case (bus.opcode)
            OP_ADD:  next_result = bus.operand_a + bus.operand_b;
            OP_SUB:  next_result = bus.operand_a - bus.operand_b;
            // Product is truncated to DATA_SIZE bits by the assignment width.
            OP_MUL:  next_result = bus.operand_a * bus.operand_b;
            // Divide by zero saturates to all ones.
            OP_DIV:  next_result = (bus.operand_b == '0) ? '1 : bus.operand_a / bus.operand_b;
            OP_AND:  next_result = DATA_SIZE'(a_true && b_true);
            OP_NAND: next_result = DATA_SIZE'(!(a_true && b_true));
            OP_OR:   next_result = DATA_SIZE'(a_true || b_true);
            OP_XOR:  next_result = bus.operand_a ^ bus.operand_b;
            // Unsigned compare: greater -> 1, equal -> 0, less -> -1.
            OP_CMP: begin
                if (bus.operand_a > bus.operand_b)
                    next_result = DATA_SIZE'(1);
                else if (bus.operand_a == bus.operand_b)
                    next_result = '0;
                else
                    next_result = '1;
            end
            OP_NOT:  next_result = DATA_SIZE'(!a_true);
            default: next_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            bus.out <= '0;
        else
            bus.out <= next_result;
    end

endmodule

// File: tb/tb_ula.sv
// tb_ula: directed-vector scoreboard bench for ula (DATA_SIZE = 11).
// Stimulus is applied on the falling edge and its hand-computed expected
// result queued; the monitor pops and compares one entry per rising edge
// on which a vector was presented.
module tb_ula;
    import ula_pkg::*;

    localparam int DS = 11;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic stim_vld = 1'b0;

    ula_if #(.DATA_SIZE(DS)) bus ();

    ula #(.DATA_SIZE(DS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [DS-1:0] exp_q[$];
    string         name_q[$];
    int            checks = 0;
    int            errors = 0;

    // Monitor: every edge that consumed a vector yields one comparison.
    initial begin
        logic          sampled;
        logic [DS-1:0] e;
        string         n;
        forever begin
            @(posedge clk);
            sampled = stim_vld;
            #1;
            if (sampled) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty: got %h, nothing expected", bus.out);
                end else begin
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    if (bus.out !== e) begin
                        errors++;
                        $display("FAIL %s: got %h expected %h", n, bus.out, e);
                    end
                end
            end
        end
    end

    task automatic drive(input logic r, input logic [OPCODE_W-1:0] op,
                         input logic [DS-1:0] a, input logic [DS-1:0] b,
                         input logic [DS-1:0] e, input string n);
        @(negedge clk);
        reset         = r;
        bus.opcode    = op;
        bus.operand_a = a;
        bus.operand_b = b;
        stim_vld      = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    initial begin
        bus.opcode    = OP_ADD;
        bus.operand_a = '0;
        bus.operand_b = '0;

        // Reset holds out at 0 even with a live operation applied.
        drive(1, OP_ADD, 10, 20, 11'd0, "reset_1");
        drive(1, OP_ADD, 10, 20, 11'd0, "reset_2");
        drive(0, OP_ADD, 10, 20, 11'd30, "reset_release_add");
        drive(1, OP_ADD, 10, 20, 11'd0, "reset_midstream");

        // Arithmetic
        drive(0, OP_ADD, 10, 20, 11'd30, "add");
        drive(0, OP_SUB, 20, 10, 11'd10, "sub");
        drive(0, OP_SUB, 0, 1, 11'h7FF, "sub_wrap");
        drive(0, OP_MUL, 24, 25, 11'd600, "mul");
        drive(0, OP_MUL, 100, 100, 11'd1808, "mul_trunc");
        drive(0, OP_DIV, 13, 5, 11'd2, "div");
        drive(0, OP_DIV, 7, 0, 11'h7FF, "div_zero");
        drive(0, OP_ADD, 11'h7FF, 1, 11'd0, "add_wrap");

        // Logic
        drive(0, OP_AND, 11'h55, 11'hAA, 11'd1, "and");
        drive(0, OP_NAND, 11'h55, 11'hAA, 11'd0, "nand");
        drive(0, OP_OR, 11'h55, 11'hAA, 11'd1, "or");
        drive(0, OP_XOR, 11'h55, 11'hAA, 11'hFF, "xor");
        drive(0, OP_AND, 11'h55, 0, 11'd0, "and_zero");
        drive(0, OP_NAND, 11'h55, 0, 11'd1, "nand_zero");
        drive(0, OP_OR, 0, 0, 11'd0, "or_zero");
        drive(0, OP_OR, 0, 11'h400, 11'd1, "or_b_only");

        // Compare and not
        drive(0, OP_CMP, 123, 122, 11'd1, "cmp_gt");
        drive(0, OP_CMP, 123, 124, 11'h7FF, "cmp_lt");
        drive(0, OP_CMP, 123, 123, 11'd0, "cmp_eq");
        drive(0, OP_NOT, 123, 5, 11'd0, "not_nonzero");
        drive(0, OP_NOT, 0, 11'h7FF, 11'd1, "not_zero");

        // Back-to-back mixed stream
        drive(0, OP_ADD, 1, 2, 11'd3, "b2b_add");
        drive(0, OP_SUB, 5, 3, 11'd2, "b2b_sub");
        drive(0, OP_XOR, 11'h0F0, 11'h00F, 11'h0FF, "b2b_xor");
        drive(0, OP_MUL, 3, 7, 11'd21, "b2b_mul");

        // Reserved opcodes
        for (int op = 10; op < 16; op++)
            drive(0, OP_ADD + 4'(op), 11'h123, 11'h456, 11'd0, $sformatf("reserved_%0d", op));

        @(negedge clk);
        stim_vld = 1'b0;

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++)
            @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, 0 required", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
